// File: rtl/qenc_pkg.sv
// Shared types and Gray-code helpers for the quadrature encoder emulator.
package qenc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EDGE = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Next {a,b} in the up direction: 00 -> 10 -> 11 -> 01 -> 00.
   function automatic logic [1:0] gray_next(input logic [1:0] ab);
      logic [1:0] r;
      case (ab)
         2'b00:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Next {a,b} in the down direction: reverse of gray_next.
   function automatic logic [1:0] gray_prev(input logic [1:0] ab);
      logic [1:0] r;
      case (ab)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b11;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/qenc_phase_timer.sv
// Loadable down-counter with a zero flag; used for phase hold and bounce window timing.
module qenc_phase_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero_c
);

   logic [W-1:0] cnt;

   // Load takes priority; otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns step commands into A/B Gray-code edges spaced
// PHASE_CYCLES apart. Define QENC_BOUNCE_EN to add contact-bounce toggles on each edge.
module quad_encoder_gen
   import qenc_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES   = 1000,
   parameter int unsigned STEP_W         = 8,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned BOUNCE_TOGGLES = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              abort,
   output logic              enc_a,
   output logic              enc_b,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  position
);

   localparam int unsigned TMR_W = $clog2(PHASE_CYCLES) + 1;

   if (PHASE_CYCLES < 2) begin : g_phase_chk
      $error("quad_encoder_gen: PHASE_CYCLES must be at least 2");
   end

   state_t            state;
   logic              dir_q;
   logic [STEP_W-1:0] remaining;
   logic              abort_seen;
   logic [1:0]        gray;

   logic              accept_c;
   logic              hold_end_c;
   logic              hold_go_c;
   logic              edge_fire_c;
   logic              dir_use_c;
   logic [1:0]        gray_adv_c;
   logic              tmr_zero_c;

   // Edge decision: a fresh non-empty command, or a completed hold with work left and no abort.
   assign accept_c    = cmd_valid && (state == ST_IDLE);
   assign hold_end_c  = (state == ST_HOLD) && tmr_zero_c;
   assign hold_go_c   = hold_end_c && (remaining != '0) && !abort_seen && !abort;
   assign edge_fire_c = (accept_c && (cmd_steps != '0)) || hold_go_c;
   assign dir_use_c   = (state == ST_IDLE) ? cmd_dir : dir_q;
   assign gray_adv_c  = (dir_use_c == DIR_UP) ? gray_next(gray) : gray_prev(gray);

   // Spacing timer: loaded as each edge fires so EDGE plus HOLD spans PHASE_CYCLES.
   qenc_phase_timer #(.W(TMR_W)) u_hold_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (edge_fire_c),
      .load_val (TMR_W'(PHASE_CYCLES - 1)),
      .en       (state != ST_IDLE),
      .zero_c   (tmr_zero_c)
   );

   // Control FSM with command latch, Gray register and position counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         dir_q      <= DIR_UP;
         remaining  <= '0;
         abort_seen <= 1'b0;
         gray       <= 2'b00;
         position   <= '0;
      end else begin
         done <= 1'b0;

         if (edge_fire_c) begin
            gray     <= gray_adv_c;
            position <= (dir_use_c == DIR_UP) ? position + CNT_W'(1) : position - CNT_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (accept_c) begin
                  dir_q      <= cmd_dir;
                  abort_seen <= 1'b0;
                  if (cmd_steps != '0) begin
                     remaining <= cmd_steps - STEP_W'(1);
                     state     <= ST_EDGE;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_EDGE: begin
               abort_seen <= abort_seen | abort;
               state      <= ST_HOLD;
            end
            ST_HOLD: begin
               abort_seen <= abort_seen | abort;
               if (hold_go_c) begin
                  remaining <= remaining - STEP_W'(1);
                  state     <= ST_EDGE;
               end else if (hold_end_c) begin
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  cmd_ready  <= 1'b1;
                  abort_seen <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef QENC_BOUNCE_EN
   localparam int unsigned BNC_W = $clog2(2 * BOUNCE_TOGGLES + 1) + 1;

   if (2 * BOUNCE_TOGGLES >= PHASE_CYCLES - 1) begin : g_bounce_chk
      $error("quad_encoder_gen: 2*BOUNCE_TOGGLES must be below PHASE_CYCLES-1");
   end

   logic [1:0] enc_q;
   logic [1:0] bmask;
   logic       bnc_zero_c;

   // Bounce window: counts the toggles applied to the line that just changed.
   qenc_phase_timer #(.W(BNC_W)) u_bounce_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (edge_fire_c),
      .load_val (BNC_W'(2 * BOUNCE_TOGGLES)),
      .en       (1'b1),
      .zero_c   (bnc_zero_c)
   );

   // Output register: jump to the new code, then toggle the changed line an even number of times.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enc_q <= 2'b00;
         bmask <= 2'b00;
      end else if (edge_fire_c) begin
         enc_q <= gray_adv_c;
         bmask <= gray ^ gray_adv_c;
      end else if (!bnc_zero_c) begin
         enc_q <= enc_q ^ bmask;
      end
   end

   assign enc_a = enc_q[1];
   assign enc_b = enc_q[0];
`else
   assign enc_a = gray[1];
   assign enc_b = gray[0];
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen with PHASE_CYCLES=4, CNT_W=8.
module tb_quad_encoder_gen;

   localparam int unsigned PH = 4;

   logic       clk;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [7:0] cmd_steps;
   logic       abort;
   logic       enc_a;
   logic       enc_b;
   logic       busy;
   logic       done;
   logic [7:0] position;

   int n_tests = 0;
   int n_fail  = 0;

   quad_encoder_gen #(
      .PHASE_CYCLES   (PH),
      .STEP_W         (8),
      .CNT_W          (8),
      .BOUNCE_TOGGLES (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .busy      (busy),
      .done      (done),
      .position  (position)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Async reset, checked 1 time unit after assertion, released on a falling clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_enc",   32'({enc_a, enc_b}), 32'h0);
      chk("rst_pos",   32'(position), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h1);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Issue a command and check each edge, the hold spacing, done latency and final state.
   task automatic run_cmd(input string tag, input logic dir, input logic [7:0] steps,
                          input int n_edges, input logic [7:0] seq, input logic [7:0] exp_pos);
      logic [1:0] prev;
      int cyc;
      prev = {enc_a, enc_b};
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = steps;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < n_edges; i++) begin
         if (i > 0) begin
            repeat (PH - 1) @(negedge clk);
            chk({tag, "_hold"}, 32'({enc_a, enc_b}), 32'(prev));
            @(negedge clk);
         end
         chk({tag, "_edge"},  32'({enc_a, enc_b}), 32'(seq[7-2*i -: 2]));
         chk({tag, "_ready"}, 32'(cmd_ready), 32'h0);
         chk({tag, "_busy"},  32'(busy), 32'h1);
         prev = seq[7-2*i -: 2];
      end
      cyc = 0;
      while (!done && cyc < 3 * PH) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_lat"}, 32'(cyc), 32'(PH));
      chk({tag, "_pos"},      32'(position), 32'(exp_pos));
      chk({tag, "_busy_end"}, 32'(busy), 32'h0);
      chk({tag, "_rdy_end"},  32'(cmd_ready), 32'h1);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 32'h0);
   endtask

   initial begin
      int cyc;
      int pulses;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b1;
      cmd_steps = 8'd0;
      abort     = 1'b0;
      @(negedge clk);
      do_reset();

      // up, 4 steps: 10,11,01,00, position 4
      run_cmd("up4", 1'b1, 8'd4, 4, 8'b10_11_01_00, 8'h04);

      // down, 3 steps from reset: 01,11,10, position 0xFD
      do_reset();
      run_cmd("dn3", 1'b0, 8'd3, 3, 8'b01_11_10_00, 8'hFD);

      // zero steps: done the cycle after accept, no edge, never busy
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("z_done", 32'(done), 32'h1);
      chk("z_busy", 32'(busy), 32'h0);
      chk("z_enc",  32'({enc_a, enc_b}), 32'h2);
      chk("z_pos",  32'(position), 32'hFD);
      @(negedge clk);
      chk("z_done_end", 32'(done), 32'h0);
      chk("z_busy_end", 32'(busy), 32'h0);

      // up 3 from 10 / 0xFD: continues Gray state, position wraps to 0
      run_cmd("wrap", 1'b1, 8'd3, 3, 8'b11_01_00_00, 8'h00);

      // abort one cycle after the 2nd edge: exactly 2 edges
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd10;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ab_e1", 32'({enc_a, enc_b}), 32'h2);
      repeat (PH) @(negedge clk);
      chk("ab_e2", 32'({enc_a, enc_b}), 32'h3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      cyc = 1;
      while (!done && cyc < 5 * PH) begin
         @(negedge clk);
         cyc++;
         if (!done) chk("ab_noedge", 32'({enc_a, enc_b}), 32'h3);
      end
      chk("ab_done_lat", 32'(cyc), 32'(PH));
      chk("ab_enc", 32'({enc_a, enc_b}), 32'h3);
      chk("ab_pos", 32'(position), 32'h02);
      chk("ab_busy", 32'(busy), 32'h0);

      // reset mid-HOLD: async clear, no done afterwards
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mr_e1",  32'({enc_a, enc_b}), 32'h1);
      chk("mr_pos", 32'(position), 32'h03);
      repeat (2) @(negedge clk);
      do_reset();
      pulses = 0;
      for (int i = 0; i < 3 * PH; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("mr_no_done", 32'(pulses), 32'h0);
      chk("mr_ready",   32'(cmd_ready), 32'h1);
      chk("mr_enc",     32'({enc_a, enc_b}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
